display_mux: RTL and testbench

Parametrised multiplexed seven-segment driver for the stopwatch board. It converts a binary value to decimal with a serial divide-by-10 engine and scans N common-anode digits with blanking guard bands. It adds overflow indication, per-digit decimal points and optional leading-zero blanking. It sits between the stopwatch counter logic and the board `seg`/`an`/`dp` pins.

---
 rtl/display_pkg.sv | 32 +++
 rtl/div10_serial.sv | 46 ++++
 rtl/display_mux.sv | 177 +++++++++++++++++
 tb/tb_display_mux.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed seven-segment driver.
package display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef enum logic [1:0] {
    LATCH,
    DIV,
    COMMIT
  } conv_state_t;

  // Active-low {g,f,e,d,c,b,a} pattern for one decimal digit; 10..15 never occur
  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] pat;
    case (d)
      4'd0:    pat = 7'h40;
      4'd1:    pat = 7'h79;
      4'd2:    pat = 7'h24;
      4'd3:    pat = 7'h30;
      4'd4:    pat = 7'h19;
      4'd5:    pat = 7'h12;
      4'd6:    pat = 7'h02;
      4'd7:    pat = 7'h78;
      4'd8:    pat = 7'h00;
      4'd9:    pat = 7'h10;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/div10_serial.sv
// One-bit-per-cycle restoring divide-by-10 step. After W shifts the
// remainder is the next decimal digit and work holds the quotient.
module div10_serial
  import display_pkg::*;
#(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic         digit_end,
  input  logic [W-1:0] din,
  output logic [W-1:0] quotient,
  output logic [3:0]   rem_next
);

  logic [W-1:0] work;
  logic [3:0]   r;
  logic [4:0]   t;
  logic         ge10;

  // Trial subtraction of 10 from the remainder with the next dividend bit appended
  always_comb begin
    t        = {r, work[W-1]};
    ge10     = (t >= 5'd10);
    rem_next = ge10 ? 4'(t - 5'd10) : t[3:0];
  end

  // Work/remainder registers; remainder restarts from zero at each digit boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      work <= '0;
      r    <= '0;
    end else if (load) begin
      work <= din;
      r    <= '0;
    end else if (shift) begin
      work <= {work[W-2:0], ge10};
      r    <= digit_end ? 4'd0 : rem_next;
    end
  end

  assign quotient = work;

endmodule

// File: rtl/display_mux.sv
// Multiplexed common-anode seven-segment driver with serial binary-to-BCD
// conversion, overflow dashes, per-digit decimal points and blanking guard
// bands. Optional leading-zero blanking is enabled by defining DISPLAY_LZB_EN.
module display_mux
  import display_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int W            = 14,
  parameter int SLOT_CYCLES  = 1000,
  parameter int BLANK_CYCLES = 100
) (
  input  logic                mclk,
  input  logic                rst,
  input  logic [W-1:0]        number,
  input  logic [N_DIGITS-1:0] dp_mask,
  output logic [6:0]          seg,
  output logic [N_DIGITS-1:0] an,
  output logic                dp,
  output logic                conv_done,
  output logic                overflow
);

  localparam int DIG_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int BIT_W  = $clog2(W);
  localparam int SLOT_W = $clog2(SLOT_CYCLES + 1);

  conv_state_t state, state_next;
  logic load, shift, commit;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DIG_W-1:0]  digit_cnt;
  logic last_bit, last_digit;
  logic [W-1:0] quotient;
  logic [3:0]   rem_next;
  logic [3:0]   shadow [N_DIGITS];
  logic [3:0]   digits [N_DIGITS];

  logic [SLOT_W-1:0] s;
  logic [DIG_W-1:0]  idx;
  logic              in_window, visible, lead_blank;
  logic [3:0]        cur_digit;
  logic [6:0]          seg_next;
  logic [N_DIGITS-1:0] an_next;
  logic                dp_next;

  assign last_bit   = (bit_cnt == BIT_W'(W - 1));
  assign last_digit = (digit_cnt == DIG_W'(N_DIGITS - 1));

  div10_serial #(.W(W)) u_div (
    .clk       (mclk),
    .rst       (rst),
    .load      (load),
    .shift     (shift),
    .digit_end (last_bit),
    .din       (number),
    .quotient  (quotient),
    .rem_next  (rem_next)
  );

  // Conversion state register
  always_ff @(posedge mclk) begin
    if (rst) state <= LATCH;
    else     state <= state_next;
  end

  // LATCH loads the divider, DIV shifts N_DIGITS*W times, COMMIT publishes digits
  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift      = 1'b0;
    commit     = 1'b0;
    unique case (state)
      LATCH: begin
        load       = 1'b1;
        state_next = DIV;
      end
      DIV: begin
        shift = 1'b1;
        if (last_bit && last_digit) state_next = COMMIT;
      end
      COMMIT: begin
        commit     = 1'b1;
        state_next = LATCH;
      end
      default: state_next = LATCH;
    endcase
  end

  // Bit and digit counters for the divide loop, plus shadow capture of each remainder
  always_ff @(posedge mclk) begin
    if (rst || load) begin
      bit_cnt   <= '0;
      digit_cnt <= '0;
      if (rst) shadow <= '{default: '0};
    end else if (shift) begin
      if (last_bit) begin
        bit_cnt           <= '0;
        digit_cnt         <= digit_cnt + 1'b1;
        shadow[digit_cnt] <= rem_next;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // Committed digit set, overflow flag and completion pulse
  always_ff @(posedge mclk) begin
    if (rst) begin
      digits    <= '{default: '0};
      overflow  <= 1'b0;
      conv_done <= 1'b0;
    end else begin
      conv_done <= commit;
      if (commit) begin
        digits   <= shadow;
        overflow <= |quotient;
      end
    end
  end

  // Slot counter and digit index for the scan
  always_ff @(posedge mclk) begin
    if (rst) begin
      s   <= '0;
      idx <= '0;
    end else if (s == SLOT_W'(SLOT_CYCLES - 1)) begin
      s   <= '0;
      idx <= (idx == DIG_W'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      s <= s + 1'b1;
    end
  end

`ifdef DISPLAY_LZB_EN
  logic [DIG_W-1:0] msd;

  // Most significant nonzero digit; digit 0 is always treated as significant
  always_comb begin
    msd = '0;
    for (int i = 1; i < N_DIGITS; i++) begin
      if (digits[i] != 4'd0) msd = DIG_W'(i);
    end
    lead_blank = !overflow && (idx > msd);
  end
`else
  assign lead_blank = 1'b0;
`endif

  // Next anode/segment/dp pattern from the current slot position and digit
  always_comb begin
    in_window = (s >= SLOT_W'(BLANK_CYCLES)) &&
                (s < SLOT_W'(SLOT_CYCLES - BLANK_CYCLES));
    visible   = in_window && !lead_blank;
    cur_digit = digits[idx];
    an_next   = '1;
    seg_next  = SEG_BLANK;
    dp_next   = 1'b1;
    if (visible) begin
      an_next[idx] = 1'b0;
      seg_next     = overflow ? SEG_DASH : seg_encode(cur_digit);
      dp_next      = !(dp_mask[idx] && !overflow);
    end
  end

  // Registered pin drivers
  always_ff @(posedge mclk) begin
    if (rst) begin
      an  <= '1;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_display_mux.sv
// Self-checking bench for display_mux: directed scenarios plus random values,
// compared every cycle against a value-level model of conversion and scanning.
module tb_display_mux;

  localparam int N  = 4;
  localparam int W  = 14;
  localparam int SC = 20;
  localparam int B  = 2;
  localparam int T  = N * W + 2;

  logic         mclk = 1'b0;
  logic         rst;
  logic [W-1:0] number;
  logic [N-1:0] dp_mask;
  logic [6:0]   seg;
  logic [N-1:0] an;
  logic         dp;
  logic         conv_done;
  logic         overflow;

  int vectors     = 0;
  int miscompares = 0;
  int e           = 0;
  int latched     = 0;
  int shown       = 0;

  always #5 mclk = ~mclk;

  display_mux #(
    .N_DIGITS     (N),
    .W            (W),
    .SLOT_CYCLES  (SC),
    .BLANK_CYCLES (B)
  ) dut (
    .mclk      (mclk),
    .rst       (rst),
    .number    (number),
    .dp_mask   (dp_mask),
    .seg       (seg),
    .an        (an),
    .dp        (dp),
    .conv_done (conv_done),
    .overflow  (overflow)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at edge %0d: got %0h expected %0h", tag, e, obs, exp);
    end
  endtask

  function automatic logic [6:0] refSeg(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      default: return 7'h10;
    endcase
  endfunction

  function automatic int pow10(input int k);
    int p = 1;
    for (int j = 0; j < k; j++) p = p * 10;
    return p;
  endfunction

  // One clock: the model predicts the registered outputs from the inputs seen at the edge
  task automatic step();
    logic         r_at;
    int           num_at, prev_shown, s, i, d;
    logic [N-1:0] mask_at, exp_an;
    logic [6:0]   exp_seg;
    logic         exp_dp, exp_done, vis, ovf_prev;
    r_at       = rst;
    num_at     = int'(number);
    mask_at    = dp_mask;
    prev_shown = shown;
    @(posedge mclk);
    #1;
    exp_an  = '1;
    exp_seg = 7'h7F;
    exp_dp  = 1'b1;
    if (r_at) begin
      e        = 0;
      shown    = 0;
      exp_done = 1'b0;
    end else begin
      e++;
      s        = (e - 1) % SC;
      i        = ((e - 1) / SC) % N;
      ovf_prev = (prev_shown >= pow10(N));
      vis      = (s >= B) && (s < SC - B);
`ifdef DISPLAY_LZB_EN
      if (!ovf_prev && i > 0 && prev_shown < pow10(i)) vis = 1'b0;
`endif
      if (vis) begin
        d         = (prev_shown / pow10(i)) % 10;
        exp_an[i] = 1'b0;
        exp_seg   = ovf_prev ? 7'h3F : refSeg(d);
        exp_dp    = !(mask_at[i] && !ovf_prev);
      end
      if ((e - 1) % T == 0) latched = num_at;
      exp_done = (e % T == 0);
      if (exp_done) shown = latched;
    end
    checkOutput("an", 32'(an), 32'(exp_an));
    checkOutput("seg", 32'(seg), 32'(exp_seg));
    checkOutput("dp", 32'(dp), 32'(exp_dp));
    checkOutput("conv_done", 32'(conv_done), 32'(exp_done));
    checkOutput("overflow", 32'(overflow), 32'(shown >= pow10(N)));
  endtask

  task automatic applyStimulus(input int num, input logic [N-1:0] mask, input int cycles);
    number  = W'(num);
    dp_mask = mask;
    repeat (cycles) step();
  endtask

  initial begin
    rst     = 1'b1;
    number  = W'(1682);
    dp_mask = '0;
    step();
    step();
    rst = 1'b0;

    $display("[TB] 1682 after reset");
    applyStimulus(1682, 4'b0000, 2 * T + 2 * N * SC);

    $display("[TB] 9999 then 10000");
    applyStimulus(9999, 4'b0000, 2 * T + N * SC);
    applyStimulus(10000, 4'b1111, 2 * T + N * SC);

    $display("[TB] 7 with decimal point on digit 2");
    applyStimulus(7, 4'b0100, 2 * T + 2 * N * SC);

    $display("[TB] reset mid-conversion with 1234");
    number = W'(1234);
    while ((e % T) < 10 || (e % T) > 40) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    applyStimulus(1234, 4'b0000, 2 * T + N * SC);

    $display("[TB] 5 changing to 42 during the divide");
    while (e % T != 0) step();
    applyStimulus(5, 4'b0000, 10);
    applyStimulus(42, 4'b0000, 3 * T);

    $display("[TB] random values");
    for (int k = 0; k < 30; k++) begin
      int sel, val;
      sel = int'($urandom_range(0, 4));
      val = (sel == 4) ? int'($urandom_range(0, 16383))
                       : int'($urandom_range(0, pow10(sel + 1) - 1));
      if ($urandom_range(0, 7) == 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
      applyStimulus(val, N'($urandom_range(0, 15)), int'($urandom_range(20, 200)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
